// File: rtl/enemy_fire_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : enemy_fire_scheduler
//  Picks which live enemy fires next and which bullet slot it uses, rate
//  limited by a cooldown. FIRE_BOTTOM_ONLY_EN: only the lowest live enemy of
//  each column may fire.
//  Revision : 1.0
// ============================================================================
module enemy_fire_scheduler #(
    parameter int N_ENEMY  = 65,
    parameter int COLS     = 13,
    parameter int N_SLOTS  = 3,
    parameter int COOLDOWN = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               restart,
    input  logic               enable,
    input  logic [N_ENEMY-1:0] enemy_vivos,
    input  logic [N_SLOTS-1:0] slot_busy,
    input  logic               shot_ready,
    output logic               shot_valid,
    output logic [6:0]         shot_id,
    output logic [3:0]         shot_col,
    output logic [2:0]         shot_row,
    output logic [1:0]         shot_slot
);

    localparam int          ROWS       = (N_ENEMY + COLS - 1) / COLS;
    localparam logic [1:0]  ST_COOL    = 2'd0;
    localparam logic [1:0]  ST_WAIT    = 2'd1;
    localparam logic [1:0]  ST_SCAN    = 2'd2;
    localparam logic [1:0]  ST_OFFER   = 2'd3;
    localparam logic [19:0] CNT_LAST   = 20'(COOLDOWN - 1);
    localparam logic [6:0]  IDX_LAST   = 7'(N_ENEMY - 1);
    localparam logic [6:0]  N_ENEMY_C  = 7'(N_ENEMY);
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    logic [1:0]  state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [6:0]  idx_q, idx_d;
    logic [6:0]  tested_q, tested_d;
    logic [6:0]  id_q, id_d;
    logic [2:0]  row_q, row_d;
    logic [3:0]  col_q, col_d;
    logic [1:0]  slot_q, slot_d;

    logic [N_ENEMY-1:0] eligible;
    logic [1:0]         free_slot;
    logic [6:0]         start_idx;
    logic [2:0]         scan_row;
    logic [3:0]         scan_col;

`ifdef FIRE_BOTTOM_ONLY_EN
    // vivos_up[k] is enemy k+COLS, zero-extended so every "below" lookup is in range
    localparam int UP_W = N_ENEMY - COLS + (ROWS - 1) * COLS;
    logic [UP_W-1:0] vivos_up;

    always_comb begin
        vivos_up = {{(UP_W - (N_ENEMY - COLS)){1'b0}}, enemy_vivos[N_ENEMY-1:COLS]};
        for (int i = 0; i < N_ENEMY; i++) begin
            eligible[i] = enemy_vivos[i];
            for (int r = 1; r < ROWS; r++) begin
                if (vivos_up[i + (r - 1) * COLS]) begin
                    eligible[i] = 1'b0;
                end
            end
        end
    end
`else
    always_comb begin
        eligible = enemy_vivos;
    end
`endif

    always_comb begin
        free_slot = 2'd0;
        for (int s = N_SLOTS - 1; s >= 0; s--) begin
            if (!slot_busy[s]) begin
                free_slot = 2'(s);
            end
        end
    end

    always_comb begin
        start_idx = (lfsr_q[6:0] >= N_ENEMY_C) ? (lfsr_q[6:0] - N_ENEMY_C) : lfsr_q[6:0];
        lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    // Row/column by comparison against multiples of COLS, avoiding a divider
    always_comb begin
        scan_row = 3'd0;
        scan_col = 4'(idx_q);
        for (int r = 1; r < ROWS; r++) begin
            if (idx_q >= 7'(r * COLS)) begin
                scan_row = 3'(r);
                scan_col = 4'(idx_q - 7'(r * COLS));
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        tested_d = tested_q;
        id_d     = id_q;
        row_d    = row_q;
        col_d    = col_q;
        slot_d   = slot_q;

        case (state_q)
            ST_COOL: begin
                if (enable) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_WAIT;
                    end else begin
                        cnt_d = cnt_q + 20'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    state_d = ST_COOL;
                    cnt_d   = 20'd0;
                end else if (!(&slot_busy)) begin
                    slot_d   = free_slot;
                    idx_d    = start_idx;
                    tested_d = 7'd0;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!enable) begin
                    state_d = ST_COOL;
                    cnt_d   = 20'd0;
                end else if (eligible[idx_q]) begin
                    id_d    = idx_q;
                    row_d   = scan_row;
                    col_d   = scan_col;
                    state_d = ST_OFFER;
                end else if (tested_q == IDX_LAST) begin
                    state_d = ST_COOL;
                    cnt_d   = 20'd0;
                end else begin
                    idx_d    = (idx_q == IDX_LAST) ? 7'd0 : idx_q + 7'd1;
                    tested_d = tested_q + 7'd1;
                end
            end
            ST_OFFER: begin
                // A pending offer survives the enemy dying or the slot filling
                if (shot_ready || !enable) begin
                    state_d = ST_COOL;
                    cnt_d   = 20'd0;
                end
            end
            default: begin
                state_d = ST_COOL;
                cnt_d   = 20'd0;
            end
        endcase

        if (restart) begin
            state_d = ST_COOL;
            cnt_d   = 20'd0;
            id_d    = 7'd0;
            row_d   = 3'd0;
            col_d   = 4'd0;
            slot_d  = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_COOL;
            cnt_q    <= 20'd0;
            lfsr_q   <= LFSR_SEED;
            idx_q    <= 7'd0;
            tested_q <= 7'd0;
            id_q     <= 7'd0;
            row_q    <= 3'd0;
            col_q    <= 4'd0;
            slot_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            idx_q    <= idx_d;
            tested_q <= tested_d;
            id_q     <= id_d;
            row_q    <= row_d;
            col_q    <= col_d;
            slot_q   <= slot_d;
        end
    end

    assign shot_valid = (state_q == ST_OFFER);
    assign shot_id    = id_q;
    assign shot_row   = row_q;
    assign shot_col   = col_q;
    assign shot_slot  = slot_q;

endmodule
`default_nettype wire

// File: tb/tb_enemy_fire_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_enemy_fire_scheduler
//  Directed self-checking bench for enemy_fire_scheduler (COOLDOWN = 8).
//  Revision : 1.0
// ============================================================================
module tb_enemy_fire_scheduler;

    localparam int N_ENEMY  = 65;
    localparam int COLS     = 13;
    localparam int N_SLOTS  = 3;
    localparam int COOLDOWN = 8;
    // cooldown cycles, one WAIT_SLOT cycle, one SCAN cycle on a hit
    localparam int LAT_FULL = COOLDOWN + 2;
`ifdef FIRE_BOTTOM_ONLY_EN
    localparam int ALIVE_EXTRA = N_ENEMY - COLS;
`else
    localparam int ALIVE_EXTRA = 0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               restart = 1'b0;
    logic               enable = 1'b0;
    logic [N_ENEMY-1:0] enemy_vivos = '1;
    logic [N_SLOTS-1:0] slot_busy = '0;
    logic               shot_ready = 1'b0;
    logic               shot_valid;
    logic [6:0]         shot_id;
    logic [3:0]         shot_col;
    logic [2:0]         shot_row;
    logic [1:0]         shot_slot;

    int total = 0;
    int bad   = 0;

    enemy_fire_scheduler #(
        .N_ENEMY (N_ENEMY),
        .COLS    (COLS),
        .N_SLOTS (N_SLOTS),
        .COOLDOWN(COOLDOWN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .restart    (restart),
        .enable     (enable),
        .enemy_vivos(enemy_vivos),
        .slot_busy  (slot_busy),
        .shot_ready (shot_ready),
        .shot_valid (shot_valid),
        .shot_id    (shot_id),
        .shot_col   (shot_col),
        .shot_row   (shot_row),
        .shot_slot  (shot_slot)
    );

    always #5 clk = ~clk;

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        while (shot_valid !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        enable = 1'b1; enemy_vivos = '1; slot_busy = '0; shot_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (shot_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", shot_valid); end
        total++; if (shot_id !== 7'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", shot_id); end
        total++; if (shot_row !== 3'd0) begin bad++; $display("FAIL reset_row: got %0d want 0", shot_row); end
        total++; if (shot_col !== 4'd0) begin bad++; $display("FAIL reset_col: got %0d want 0", shot_col); end
        total++; if (shot_slot !== 2'd0) begin bad++; $display("FAIL reset_slot: got %0d want 0", shot_slot); end
    endtask

    task automatic test_first_shot();
        int n;
        reset = 1'b1;
        wait_valid(200, n);
        total++;
        if (n < LAT_FULL || n > LAT_FULL + ALIVE_EXTRA || shot_valid !== 1'b1) begin
            bad++; $display("FAIL first_latency: got %0d want %0d", n, LAT_FULL);
        end
        total++; if (shot_slot !== 2'd0) begin bad++; $display("FAIL first_slot: got %0d want 0", shot_slot); end
        total++; if (int'(shot_id) >= N_ENEMY) begin bad++; $display("FAIL first_id_range: got %0d want <%0d", shot_id, N_ENEMY); end
        total++; if (int'(shot_row) != int'(shot_id) / COLS) begin bad++; $display("FAIL first_row: got %0d want %0d", shot_row, int'(shot_id) / COLS); end
        total++; if (int'(shot_col) != int'(shot_id) % COLS) begin bad++; $display("FAIL first_col: got %0d want %0d", shot_col, int'(shot_id) % COLS); end
        @(negedge clk);
        total++; if (shot_valid !== 1'b0) begin bad++; $display("FAIL first_handshake_drop: got %b want 0", shot_valid); end
    endtask

    task automatic test_single_enemy();
        int n;
        enemy_vivos = '0;
        enemy_vivos[40] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid(COOLDOWN + N_ENEMY + 20, n);
            total++;
            if (n < LAT_FULL || n > COOLDOWN + N_ENEMY + 10 || shot_valid !== 1'b1) begin
                bad++; $display("FAIL single_latency: got %0d want <=%0d", n, COOLDOWN + N_ENEMY + 10);
            end
            total++; if (shot_id !== 7'd40) begin bad++; $display("FAIL single_id: got %0d want 40", shot_id); end
            total++; if (shot_row !== 3'd3) begin bad++; $display("FAIL single_row: got %0d want 3", shot_row); end
            total++; if (shot_col !== 4'd1) begin bad++; $display("FAIL single_col: got %0d want 1", shot_col); end
            @(negedge clk);
        end
    endtask

    task automatic test_slot_busy();
        int n;
        int seen;
        enemy_vivos = '1;
        slot_busy = 3'b111;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (shot_valid === 1'b1) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL busy_no_offer: got %0d offers want 0", seen); end
        slot_busy = 3'b101;
        wait_valid(100, n);
        total++;
        if (n < 2 || n > 2 + ALIVE_EXTRA || shot_valid !== 1'b1) begin
            bad++; $display("FAIL busy_release_latency: got %0d want 2", n);
        end
        total++; if (shot_slot !== 2'd1) begin bad++; $display("FAIL busy_slot: got %0d want 1", shot_slot); end
        @(negedge clk);
        slot_busy = 3'b000;
    endtask

    task automatic test_backpressure();
        int n;
        int err_v;
        int err_o;
        logic [6:0] id0;
        logic [2:0] row0;
        logic [3:0] col0;
        logic [1:0] slot0;
        shot_ready = 1'b0;
        wait_valid(200, n);
        total++;
        if (n < LAT_FULL || n > LAT_FULL + ALIVE_EXTRA || shot_valid !== 1'b1) begin
            bad++; $display("FAIL bp_latency: got %0d want %0d", n, LAT_FULL);
        end
        id0 = shot_id; row0 = shot_row; col0 = shot_col; slot0 = shot_slot;
        enemy_vivos[id0] = 1'b0;
        slot_busy = 3'b111;
        err_v = 0; err_o = 0;
        repeat (20) begin
            @(negedge clk);
            if (shot_valid !== 1'b1) err_v++;
            if (shot_id !== id0 || shot_row !== row0 || shot_col !== col0 || shot_slot !== slot0) err_o++;
        end
        total++; if (err_v != 0) begin bad++; $display("FAIL bp_valid_hold: got %0d drops want 0", err_v); end
        total++; if (err_o != 0) begin bad++; $display("FAIL bp_outputs_hold: got %0d changes want 0", err_o); end
        shot_ready = 1'b1;
        @(negedge clk);
        shot_ready = 1'b0;
        total++; if (shot_valid !== 1'b0) begin bad++; $display("FAIL bp_handshake_drop: got %b want 0", shot_valid); end
        enemy_vivos = '1;
        slot_busy = 3'b000;
        wait_valid(200, n);
        total++;
        if (n < LAT_FULL || n > LAT_FULL + ALIVE_EXTRA || shot_valid !== 1'b1) begin
            bad++; $display("FAIL bp_next_latency: got %0d want %0d", n, LAT_FULL);
        end
    endtask

    task automatic test_restart();
        int n;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        total++; if (shot_valid !== 1'b0) begin bad++; $display("FAIL restart_valid: got %b want 0", shot_valid); end
        total++;
        if (shot_id !== 7'd0 || shot_row !== 3'd0 || shot_col !== 4'd0 || shot_slot !== 2'd0) begin
            bad++; $display("FAIL restart_outputs: got id=%0d row=%0d col=%0d slot=%0d want all 0", shot_id, shot_row, shot_col, shot_slot);
        end
        wait_valid(200, n);
        total++;
        if (n < LAT_FULL || n > LAT_FULL + ALIVE_EXTRA || shot_valid !== 1'b1) begin
            bad++; $display("FAIL restart_latency: got %0d want %0d", n, LAT_FULL);
        end
    endtask

    task automatic test_reset_async();
        int n;
        reset = 1'b0;
        #1;
        total++; if (shot_valid !== 1'b0) begin bad++; $display("FAIL async_reset_valid: got %b want 0", shot_valid); end
        total++; if (shot_id !== 7'd0) begin bad++; $display("FAIL async_reset_id: got %0d want 0", shot_id); end
        @(negedge clk);
        reset = 1'b1;
        wait_valid(200, n);
        total++;
        if (n < LAT_FULL || n > LAT_FULL + ALIVE_EXTRA || shot_valid !== 1'b1) begin
            bad++; $display("FAIL async_reset_latency: got %0d want %0d", n, LAT_FULL);
        end
    endtask

    task automatic test_reset_mid_scan();
        int n;
        shot_ready = 1'b1;
        @(negedge clk);
        shot_ready = 1'b0;
        enemy_vivos = '0;
        enemy_vivos[40] = 1'b1;
        repeat (COOLDOWN + 1) @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (shot_valid !== 1'b0) begin bad++; $display("FAIL scan_reset_valid: got %b want 0", shot_valid); end
        total++; if (shot_id !== 7'd0) begin bad++; $display("FAIL scan_reset_id: got %0d want 0", shot_id); end
        enemy_vivos = '1;
        @(negedge clk);
        reset = 1'b1;
        wait_valid(200, n);
        total++;
        if (n < LAT_FULL || n > LAT_FULL + ALIVE_EXTRA || shot_valid !== 1'b1) begin
            bad++; $display("FAIL scan_reset_latency: got %0d want %0d", n, LAT_FULL);
        end
    endtask

    task automatic test_enable();
        int n;
        int seen;
        enable = 1'b0;
        @(negedge clk);
        total++; if (shot_valid !== 1'b0) begin bad++; $display("FAIL enable_drop_valid: got %b want 0", shot_valid); end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (shot_valid === 1'b1) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL enable_low_offer: got %0d offers want 0", seen); end
        enable = 1'b1;
        wait_valid(200, n);
        total++;
        if (n < LAT_FULL || n > LAT_FULL + ALIVE_EXTRA || shot_valid !== 1'b1) begin
            bad++; $display("FAIL enable_restart_latency: got %0d want %0d", n, LAT_FULL);
        end
        shot_ready = 1'b1;
        @(negedge clk);
        shot_ready = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        enable = 1'b1;
        wait_valid(200, n);
        total++;
        if (n < LAT_FULL - 4 || n > LAT_FULL - 4 + ALIVE_EXTRA || shot_valid !== 1'b1) begin
            bad++; $display("FAIL enable_hold_latency: got %0d want %0d", n, LAT_FULL - 4);
        end
    endtask

    task automatic test_all_dead();
        int n;
        int seen;
        shot_ready = 1'b1;
        @(negedge clk);
        enemy_vivos = '0;
        seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (shot_valid === 1'b1) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL all_dead_offer: got %0d offers want 0", seen); end
        enemy_vivos[40] = 1'b1;
        wait_valid(2 * N_ENEMY + COOLDOWN + 40, n);
        total++; if (shot_valid !== 1'b1 || shot_id !== 7'd40) begin bad++; $display("FAIL all_dead_recover: got valid=%b id=%0d want valid=1 id=40", shot_valid, shot_id); end
        @(negedge clk);
    endtask

    task automatic test_eligibility();
        int n;
        int err;
        bit seen1, seen14, seen27;
        enemy_vivos = '0;
        enemy_vivos[1] = 1'b1;
        enemy_vivos[14] = 1'b1;
        enemy_vivos[27] = 1'b1;
        shot_ready = 1'b1;
        seen1 = 0; seen14 = 0; seen27 = 0;
        for (int k = 0; k < 200; k++) begin
            wait_valid(COOLDOWN + N_ENEMY + 20, n);
            total++;
            if (shot_valid !== 1'b1) begin
                bad++; $display("FAIL elig_timeout: got %0d cycles want offer", n);
                break;
            end
`ifdef FIRE_BOTTOM_ONLY_EN
            err = (shot_id !== 7'd27) ? 1 : 0;
`else
            err = (shot_id !== 7'd1 && shot_id !== 7'd14 && shot_id !== 7'd27) ? 1 : 0;
`endif
            if (err != 0) begin bad++; $display("FAIL elig_id: got %0d want allowed id", shot_id); end
            if (shot_id == 7'd27) begin
                total++;
                if (shot_row !== 3'd2 || shot_col !== 4'd1) begin
                    bad++; $display("FAIL elig_rowcol27: got row=%0d col=%0d want row=2 col=1", shot_row, shot_col);
                end
            end
            if (shot_id == 7'd1) seen1 = 1;
            if (shot_id == 7'd14) seen14 = 1;
            if (shot_id == 7'd27) seen27 = 1;
            @(negedge clk);
        end
`ifndef FIRE_BOTTOM_ONLY_EN
        total++;
        if (!(seen1 && seen14 && seen27)) begin
            bad++; $display("FAIL elig_coverage: got seen1=%0d seen14=%0d seen27=%0d want all 1", seen1, seen14, seen27);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_first_shot();
        test_single_enemy();
        test_slot_busy();
        test_backpressure();
        test_restart();
        test_reset_async();
        test_reset_mid_scan();
        test_enable();
        test_all_dead();
        test_eligibility();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
